// File: rtl/cflog_ctrl.sv
// Control-flow log write sequencer: buffers (src, dest) branch events in a
// small FIFO and drains them one per cycle into the log memory.
module cflog_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] PTR_STEP   = 16'h0002,
  parameter logic [15:0] LOG_LIMIT  = 16'h0200
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        ev_valid,
  input  logic [15:0] ev_src,
  input  logic [15:0] ev_dest,
  output logic        ev_ready,
  input  logic        log_clr,
  input  logic        full_ack,
  output logic [15:0] cflow_src,
  output logic [15:0] cflow_dest,
  output logic        cflow_hw_wen,
  output logic [15:0] cflow_logs_ptr_din,
  output logic        log_full,
  output logic [2:0]  fifo_level,
  output logic        busy
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, FULL, CLEAR} state_t;

  state_t          state, state_nxt;
  logic [15:0]     ptr, ptr_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [2:0]      level;
  logic [15:0]     src_mem  [FIFO_DEPTH];
  logic [15:0]     dest_mem [FIFO_DEPTH];
  logic            clr_req, push, pop, flush, wen;

  assign clr_req = log_clr | full_ack;

  // Gated by reset so the handshake is dead while reset is asserted.
  assign ev_ready = puc_rst_n && (level < DEPTH_L) && (state != FULL) &&
                    (state != CLEAR) && !clr_req;
  assign push     = ev_valid & ev_ready;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    pop       = 1'b0;
    flush     = 1'b0;
    wen       = 1'b0;
    log_full  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          flush     = 1'b1;
          state_nxt = CLEAR;
        end else if (level != 3'd0) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // A clear in the write cycle wins: the head entry is discarded unwritten.
        if (clr_req) begin
          flush     = 1'b1;
          state_nxt = CLEAR;
        end else begin
          wen     = 1'b1;
          pop     = 1'b1;
          ptr_nxt = ptr + PTR_STEP;
          if (ptr_nxt == LOG_LIMIT)         state_nxt = FULL;
          else if ((level > 3'd1) || push)  state_nxt = WRITE;
          else                              state_nxt = IDLE;
        end
      end
      FULL: begin
        log_full = 1'b1;
        if (clr_req) begin
          flush     = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        flush     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) ptr_nxt = 16'h0000;
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state  <= IDLE;
      ptr    <= 16'h0000;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 3'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= 3'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 3'd1;
          2'b01:   level <= level - 3'd1;
          default: level <= level;
        endcase
      end
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge mclk) begin
    if (push) begin
      src_mem[wr_ptr]  <= ev_src;
      dest_mem[wr_ptr] <= ev_dest;
    end
  end

  assign cflow_hw_wen       = wen;
  assign cflow_src          = wen ? src_mem[rd_ptr]  : 16'h0000;
  assign cflow_dest         = wen ? dest_mem[rd_ptr] : 16'h0000;
  assign cflow_logs_ptr_din = wen ? ptr_nxt : ptr;
  assign fifo_level         = level;
  assign busy               = (level != 3'd0) || (state == WRITE);

endmodule

// File: tb/tb_cflog_ctrl.sv
// Directed bench for cflog_ctrl: per-cycle vector table on a default instance,
// hand sequences for fill-to-limit (small LOG_LIMIT instance) and async reset.
module tb_cflog_ctrl;

  logic        mclk = 1'b0;
  logic        rst_n;
  always #5 mclk = ~mclk;

  logic        valid, clr, ack;
  logic [15:0] src, dest;
  logic        ready, wen, full, busy;
  logic [15:0] osrc, odest, pd;
  logic [2:0]  lvl;

  logic        l_valid, l_clr, l_ack;
  logic [15:0] l_src, l_dest;
  logic        l_ready, l_wen, l_full, l_busy;
  logic [15:0] l_osrc, l_odest, l_pd;
  logic [2:0]  l_lvl;

  cflog_ctrl dut (
    .mclk(mclk), .puc_rst_n(rst_n), .ev_valid(valid), .ev_src(src), .ev_dest(dest),
    .ev_ready(ready), .log_clr(clr), .full_ack(ack), .cflow_src(osrc), .cflow_dest(odest),
    .cflow_hw_wen(wen), .cflow_logs_ptr_din(pd), .log_full(full), .fifo_level(lvl), .busy(busy)
  );

  cflog_ctrl #(.FIFO_DEPTH(4), .PTR_STEP(16'h0002), .LOG_LIMIT(16'h0008)) dut_lim (
    .mclk(mclk), .puc_rst_n(rst_n), .ev_valid(l_valid), .ev_src(l_src), .ev_dest(l_dest),
    .ev_ready(l_ready), .log_clr(l_clr), .full_ack(l_ack), .cflow_src(l_osrc), .cflow_dest(l_odest),
    .cflow_hw_wen(l_wen), .cflow_logs_ptr_din(l_pd), .log_full(l_full), .fifo_level(l_lvl), .busy(l_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [15:0] src, dest;
    logic        clr, ack;
    logic        rdy, wen;
    logic [15:0] osrc, odest, pd;
    logic        full;
    logic [2:0]  lvl;
    logic        busy;
  } vec_t;

  function automatic vec_t v(logic va, logic [15:0] s, logic [15:0] d, logic c, logic a,
                             logic r, logic w, logic [15:0] os, logic [15:0] od,
                             logic [15:0] p, logic f, logic [2:0] l, logic b);
    vec_t t;
    t.valid = va; t.src = s; t.dest = d; t.clr = c; t.ack = a;
    t.rdy = r; t.wen = w; t.osrc = os; t.odest = od; t.pd = p;
    t.full = f; t.lvl = l; t.busy = b;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int sent, nw, n;
    rst_n = 1'b0;
    valid = 0; src = 0; dest = 0; clr = 0; ack = 0;
    l_valid = 0; l_src = 0; l_dest = 0; l_clr = 0; l_ack = 0;

    // inputs: valid src dest clr ack | expected: ready wen osrc odest ptr_din full level busy
    // single event
    vecs.push_back(v(1, 16'hE010, 16'hE200, 0, 0,  1, 0, 16'h0,    16'h0,    16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 0, 16'h0,    16'h0,    16'h0000, 0, 1, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 1, 16'hE010, 16'hE200, 16'h0002, 0, 1, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 0, 16'h0,    16'h0,    16'h0002, 0, 0, 0));
    // six back-to-back events, push and pop together at level 2
    vecs.push_back(v(1, 16'h1000, 16'h2000, 0, 0,  1, 0, 16'h0,    16'h0,    16'h0002, 0, 0, 0));
    vecs.push_back(v(1, 16'h1001, 16'h2001, 0, 0,  1, 0, 16'h0,    16'h0,    16'h0002, 0, 1, 1));
    vecs.push_back(v(1, 16'h1002, 16'h2002, 0, 0,  1, 1, 16'h1000, 16'h2000, 16'h0004, 0, 2, 1));
    vecs.push_back(v(1, 16'h1003, 16'h2003, 0, 0,  1, 1, 16'h1001, 16'h2001, 16'h0006, 0, 2, 1));
    vecs.push_back(v(1, 16'h1004, 16'h2004, 0, 0,  1, 1, 16'h1002, 16'h2002, 16'h0008, 0, 2, 1));
    vecs.push_back(v(1, 16'h1005, 16'h2005, 0, 0,  1, 1, 16'h1003, 16'h2003, 16'h000A, 0, 2, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 1, 16'h1004, 16'h2004, 16'h000C, 0, 2, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 1, 16'h1005, 16'h2005, 16'h000E, 0, 1, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 0, 16'h0,    16'h0,    16'h000E, 0, 0, 0));
    // log_clr on the second write of a 3-event burst
    vecs.push_back(v(1, 16'h3000, 16'h4000, 0, 0,  1, 0, 16'h0,    16'h0,    16'h000E, 0, 0, 0));
    vecs.push_back(v(1, 16'h3001, 16'h4001, 0, 0,  1, 0, 16'h0,    16'h0,    16'h000E, 0, 1, 1));
    vecs.push_back(v(1, 16'h3002, 16'h4002, 0, 0,  1, 1, 16'h3000, 16'h4000, 16'h0010, 0, 2, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    1, 0,  0, 0, 16'h0,    16'h0,    16'h0010, 0, 2, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  0, 0, 16'h0,    16'h0,    16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 16'h5000, 16'h6000, 0, 0,  1, 0, 16'h0,    16'h0,    16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 0, 16'h0,    16'h0,    16'h0000, 0, 1, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 1, 16'h5000, 16'h6000, 16'h0002, 0, 1, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 0, 16'h0,    16'h0,    16'h0002, 0, 0, 0));
    // full_ack in IDLE acts as a clear; offered event refused until back in IDLE
    vecs.push_back(v(1, 16'h7000, 16'h7100, 0, 1,  0, 0, 16'h0,    16'h0,    16'h0002, 0, 0, 0));
    vecs.push_back(v(1, 16'h7000, 16'h7100, 0, 0,  0, 0, 16'h0,    16'h0,    16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 16'h7000, 16'h7100, 0, 0,  1, 0, 16'h0,    16'h0,    16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 0, 16'h0,    16'h0,    16'h0000, 0, 1, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 1, 16'h7000, 16'h7100, 16'h0002, 0, 1, 1));
    vecs.push_back(v(0, 16'h0,    16'h0,    0, 0,  1, 0, 16'h0,    16'h0,    16'h0002, 0, 0, 0));

    // reset state
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    chk("rst_ready", ready, 0); chk("rst_wen", wen, 0); chk("rst_ptr", pd, 0);
    chk("rst_full", full, 0);   chk("rst_level", lvl, 0); chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge mclk); #1;
      valid = vecs[i].valid; src = vecs[i].src; dest = vecs[i].dest;
      clr = vecs[i].clr; ack = vecs[i].ack;
      @(negedge mclk);
      chk($sformatf("v%0d_ready", i), ready, vecs[i].rdy);
      chk($sformatf("v%0d_wen", i),   wen,   vecs[i].wen);
      chk($sformatf("v%0d_src", i),   osrc,  vecs[i].osrc);
      chk($sformatf("v%0d_dest", i),  odest, vecs[i].odest);
      chk($sformatf("v%0d_ptr", i),   pd,    vecs[i].pd);
      chk($sformatf("v%0d_full", i),  full,  vecs[i].full);
      chk($sformatf("v%0d_level", i), lvl,   vecs[i].lvl);
      chk($sformatf("v%0d_busy", i),  busy,  vecs[i].busy);
    end
    @(posedge mclk); #1;
    valid = 0; clr = 0; ack = 0;

    // fill to LOG_LIMIT=8 with 5 events
    sent = 0; nw = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge mclk); #1;
      l_valid = (sent < 5);
      l_src   = 16'(32'h8000 + sent);
      l_dest  = 16'(32'h9000 + sent);
      @(negedge mclk);
      if (l_wen) begin
        chk("fill_src", l_osrc, 16'(32'h8000 + nw));
        chk("fill_dest", l_odest, 16'(32'h9000 + nw));
        chk("fill_ptr", l_pd, 16'(2 * (nw + 1)));
        chk("fill_full_in_write", l_full, 0);
        nw++;
      end
      if (l_valid && l_ready) sent++;
    end
    chk("fill_writes", 16'(nw), 16'd4);
    chk("fill_accepted", 16'(sent), 16'd5);
    chk("fill_full", l_full, 1);
    chk("fill_level", l_lvl, 1);
    chk("fill_ptr_hold", l_pd, 16'h0008);
    @(posedge mclk); #1;
    l_valid = 1; l_src = 16'hA000; l_dest = 16'hB000;
    @(negedge mclk);
    chk("full_ready", l_ready, 0); chk("full_wen", l_wen, 0); chk("full_busy", l_busy, 1);
    @(posedge mclk); #1;
    l_ack = 1;
    @(negedge mclk);
    chk("ack_full", l_full, 1); chk("ack_ready", l_ready, 0);
    @(posedge mclk); #1;
    l_ack = 0; l_valid = 0;
    @(negedge mclk);
    chk("clear_full", l_full, 0); chk("clear_ptr", l_pd, 0); chk("clear_level", l_lvl, 0);
    chk("clear_ready", l_ready, 0); chk("clear_wen", l_wen, 0);
    @(posedge mclk); #1;
    @(negedge mclk);
    chk("post_clear_ready", l_ready, 1); chk("post_clear_busy", l_busy, 0);

    // asynchronous reset in the middle of a burst
    @(posedge mclk); #1;
    valid = 1; src = 16'hAB00; dest = 16'hCD00;
    @(posedge mclk); #1;
    src = 16'hAB01; dest = 16'hCD01;
    @(posedge mclk); #1;
    src = 16'hAB02; dest = 16'hCD02;
    chk("pre_rst_wen", wen, 1);
    chk("pre_rst_ptr", pd, 16'h0004);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 0); chk("arst_wen", wen, 0); chk("arst_src", osrc, 0);
    chk("arst_dest", odest, 0);  chk("arst_ptr", pd, 0);  chk("arst_full", full, 0);
    chk("arst_level", lvl, 0);   chk("arst_busy", busy, 0);
    valid = 0;
    @(posedge mclk);
    @(negedge mclk);
    rst_n = 1'b1;
    @(posedge mclk); #1;
    valid = 1; src = 16'h1234; dest = 16'h5678;
    #1 chk("after_rst_ready", ready, 1);
    @(posedge mclk); #1;
    valid = 0;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge mclk);
      if (wen) begin
        n = k;
        break;
      end
    end
    chk("after_rst_latency", 16'(n), 16'd2);
    chk("after_rst_ptr", pd, 16'h0002);
    chk("after_rst_src", osrc, 16'h1234);
    chk("after_rst_dest", odest, 16'h5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
